// File: rtl/controller_block_assembler.sv
// Pops multi-word packets from the controller FIFO and assembles them into BLAKE2b message blocks.
// Each block is offered to the compression core with its byte counter t and final flag.
module controller_block_assembler #(
    parameter int DBITS       = 64,
    parameter int RD_PKT      = 4,
    parameter int BLOCK_WORDS = 16,
    parameter int CNT_W       = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         msg_start,
    input  logic [CNT_W-1:0]             msg_len,
    input  logic                         fifo_empty,
    output logic                         fifo_rd,
    input  logic [DBITS*RD_PKT-1:0]      fifo_dout,
    output logic                         block_valid,
    input  logic                         core_ready,
    output logic [DBITS*BLOCK_WORDS-1:0] block_data,
    output logic [CNT_W-1:0]             block_counter,
    output logic                         block_final,
    output logic                         busy,
    output logic                         msg_done
);

    localparam int PKT_W     = DBITS * RD_PKT;
    localparam int BLK_W     = DBITS * BLOCK_WORDS;
    localparam int PKT_BYTES = PKT_W / 8;
    localparam int BLK_BYTES = BLK_W / 8;
    localparam int NPKT      = BLOCK_WORDS / RD_PKT;
    localparam int IDX_W     = (NPKT > 1) ? $clog2(NPKT) : 1;
    localparam int PKT_SH    = $clog2(PKT_BYTES);
    localparam bit PKT_POW2  = ((1 << PKT_SH) == PKT_BYTES);

    localparam logic [CNT_W-1:0] BLK_BYTES_C = CNT_W'(BLK_BYTES);
    localparam logic [CNT_W-1:0] PKT_BYTES_C = CNT_W'(PKT_BYTES);
    localparam logic [CNT_W-1:0] NPKT_C      = CNT_W'(NPKT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ISSUE   = 2'd3
    } state_t;

    // Bytes of the current block that belong to the message.
    function automatic logic [CNT_W-1:0] blen_f(input logic [CNT_W-1:0] rem);
        if (rem >= BLK_BYTES_C) begin
            blen_f = BLK_BYTES_C;
        end else begin
            blen_f = rem;
        end
    endfunction

    // Packets to pop for the current block: full block or ceil(rem / PKT_BYTES).
    function automatic logic [CNT_W-1:0] need_f(input logic [CNT_W-1:0] rem);
        if (rem >= BLK_BYTES_C) begin
            need_f = NPKT_C;
        end else if (PKT_POW2) begin
            need_f = (rem + PKT_BYTES_C - CNT_W'(1)) >> PKT_SH;
        end else begin
            need_f = (rem + PKT_BYTES_C - CNT_W'(1)) / PKT_BYTES_C;
        end
    endfunction

    // Zero every byte at or beyond the message end within the block.
    function automatic logic [BLK_W-1:0] mask_f(input logic [BLK_W-1:0] data,
                                                input logic [CNT_W-1:0] blen);
        logic [BLK_W-1:0] res;
        res = {BLK_W{1'b0}};
        for (int k = 0; k < BLK_BYTES; k++) begin
            if (CNT_W'(k) < blen) begin
                res[8*k +: 8] = data[8*k +: 8];
            end else begin
                res[8*k +: 8] = 8'h00;
            end
        end
        return res;
    endfunction

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             rem_q, rem_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NPKT-1:0][PKT_W-1:0]   buf_q, buf_d;
    logic                         done_d;
    logic [CNT_W-1:0]             blen_cur_s;
    logic                         final_cur_s;
    logic [CNT_W-1:0]             need_s;
    logic [CNT_W-1:0]             idx_next_s;
    logic                         accept_s;

    logic                         valid_q, valid_d;
    logic [BLK_W-1:0]             data_q, data_d;
    logic [CNT_W-1:0]             counter_q, counter_d;
    logic                         final_q, final_d;
    logic                         busy_q, busy_d;
    logic                         done_q;
    logic [CNT_W-1:0]             blen_nxt_s;

    assign fifo_rd       = (state_q == S_FETCH) && !fifo_empty;
    assign block_valid   = valid_q;
    assign block_data    = data_q;
    assign block_counter = counter_q;
    assign block_final   = final_q;
    assign busy          = busy_q;
    assign msg_done      = done_q;

    // Next-state logic for the assembly FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        done_d      = 1'b0;
        blen_cur_s  = blen_f(rem_q);
        final_cur_s = (rem_q <= BLK_BYTES_C);
        need_s      = need_f(rem_q);
        idx_next_s  = {{(CNT_W-IDX_W){1'b0}}, idx_q} + CNT_W'(1);
        accept_s    = valid_q && core_ready;

        case (state_q)
            S_IDLE: begin
                if (msg_start) begin
                    rem_d = msg_len;
                    cnt_d = {CNT_W{1'b0}};
                    idx_d = {IDX_W{1'b0}};
                    buf_d = {BLK_W{1'b0}};
                    if (msg_len == {CNT_W{1'b0}}) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_CAPTURE: begin
                buf_d[idx_q] = fifo_dout;
                if (idx_next_s == need_s) begin
                    state_d = S_ISSUE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (accept_s) begin
                    cnt_d  = cnt_q + blen_cur_s;
                    rem_d  = rem_q - blen_cur_s;
                    buf_d  = {BLK_W{1'b0}};
                    idx_d  = {IDX_W{1'b0}};
                    done_d = final_cur_s;
                    if (final_cur_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Block outputs are computed from next-state values so they are registered yet valid on ISSUE entry.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        valid_d    = (state_d == S_ISSUE);
        blen_nxt_s = blen_f(rem_d);
        if (valid_d) begin
            data_d    = mask_f(buf_d, blen_nxt_s);
            counter_d = cnt_d + blen_nxt_s;
            final_d   = (rem_d <= BLK_BYTES_C);
        end else begin
            data_d    = {BLK_W{1'b0}};
            counter_d = {CNT_W{1'b0}};
            final_d   = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rem_q     <= {CNT_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            buf_q     <= {BLK_W{1'b0}};
            valid_q   <= 1'b0;
            data_q    <= {BLK_W{1'b0}};
            counter_q <= {CNT_W{1'b0}};
            final_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            counter_q <= counter_d;
            final_q   <= final_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/controller_block_assembler.md
Name: controller_block_assembler

Overview:
- Sits directly downstream of the controller's packet FIFO. It pops multi-word packets, assembles them into one BLAKE2b message block (BLOCK_WORDS x DBITS), and hands each block to the compression core over a valid/ready handshake.
- Supplies the core's byte counter t and the final-block flag for each block.
- Tracks the message length and zero-masks bytes beyond the message end in the last block.

Parameters:
- DBITS, 64, FIFO word width in bits; must be a multiple of 8.
- RD_PKT, 4, words per FIFO packet; BLOCK_WORDS % RD_PKT == 0.
- BLOCK_WORDS, 16, words per message block.
- CNT_W, 64, width of the length and byte-counter fields.
- Derived: PKT_W = DBITS*RD_PKT; BLK_W = DBITS*BLOCK_WORDS; PKT_BYTES = PKT_W/8; BLK_BYTES = BLK_W/8; NPKT = BLOCK_WORDS/RD_PKT.

Ports:
- clk  in  1  clock, single domain.
- reset_n  in  1  asynchronous, active-low reset.
- msg_start  in  1  one-cycle pulse; starts a message of msg_len bytes.
- msg_len  in  CNT_W  total message length in bytes; sampled when msg_start is accepted.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  FIFO pop request.
- fifo_dout  in  PKT_W  FIFO packet; valid in the cycle after fifo_rd.
- block_valid  out  1  block offered to the core.
- core_ready  in  1  core accepts the block when block_valid && core_ready.
- block_data  out  BLK_W  assembled block; packet j occupies bits [PKT_W*j +: PKT_W]; byte k of the block is bits [8k +: 8] (little-endian).
- block_counter  out  CNT_W  bytes consumed including this block (BLAKE2 t).
- block_final  out  1  this block is the last of the message.
- busy  out  1  high in every state except IDLE.
- msg_done  out  1  one-cycle pulse after the final block is accepted.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs, the block buffer, remaining, count and pkt_idx are cleared to 0. This applies identically mid-message; a partially assembled block is discarded.
- All outputs are registered, except fifo_rd, which is a decode of state FETCH && !fifo_empty.

State IDLE:
- msg_start accepted: remaining<=msg_len; count<=0; pkt_idx<=0; buffer<=0.
- If msg_len==0 -> ISSUE with final=1 and counter=0 (one all-zero block). Otherwise -> FETCH.
- msg_start in any other state is ignored.

State FETCH:
- fifo_rd=1 while fifo_empty==0, then -> CAPTURE.
- While fifo_empty==1, stay in FETCH with fifo_rd=0 (no timeout).

State CAPTURE (the cycle after the pop):
- buffer[pkt_idx] <= fifo_dout.
- need = (remaining >= BLK_BYTES) ? NPKT : ceil(remaining/PKT_BYTES).
- If pkt_idx+1 == need -> ISSUE; otherwise pkt_idx++ and -> FETCH.
- Exactly need pops per block; never pop more than the message requires.

State ISSUE:
- blen = min(remaining, BLK_BYTES).
- Outputs held stable while waiting:
  - block_valid=1.
  - block_data = buffer with bytes at index >= blen forced to 0.
  - block_counter = count + blen.
  - block_final = (remaining <= BLK_BYTES).
- block_data, block_counter and block_final stay stable until core_ready.
- On block_valid && core_ready: count += blen; remaining -= blen; buffer<=0; pkt_idx<=0; block_valid drops in the next cycle.
  - If final -> IDLE with msg_done=1 for one cycle.
  - Otherwise -> FETCH.
- A length that is an exact multiple of BLK_BYTES ends on a full final block; no extra padding block is produced.

Arithmetic:
- count and remaining are CNT_W wide and unsigned; no overflow checking.
- The ceil division uses a shift when PKT_BYTES is a power of two.

Minimum latency per full block: 2*NPKT cycles of FETCH/CAPTURE plus 1 ISSUE cycle with core_ready=1 (9 cycles at the defaults).

Test Plan:
- msg_len=0: no fifo_rd ever. One block issued with block_data=0, block_counter=0, block_final=1; msg_done one cycle after acceptance.
- msg_len=128, FIFO preloaded with 16 words 0x01..0x10: 4 pops. One block with word i = i+1, block_counter=128, block_final=1.
- msg_len=200, 25 words preloaded with the last word 0xFFFF_FFFF_FFFF_FFFF:
  - Block 0: full, counter=128, final=0.
  - Block 1: 3 pops, counter=200, final=1; bytes 72..127 are 0 and word 8 is 0xFFFF_FFFF_FFFF_FFFF.
- fifo_empty held high for 10 cycles mid-block: fifo_rd stays 0 and no state advance. Assembly resumes when fifo_empty falls, with the block contents unchanged.
- core_ready held low for 5 cycles in ISSUE: block_valid, block_data, block_counter and block_final are stable; a msg_start pulse during this window is ignored.
- reset_n pulsed low in CAPTURE of block 1 of a 300-byte message: all outputs are 0 and state=IDLE immediately. A new msg_len=64 then yields one block with counter=64 and final=1.
